// File: rtl/mem_arbiter_pkg.sv
// Shared constants for mem_arbiter: FSM states, ls_op field layout, width codes,
// fetch op code and the default I/O segment.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2,
    ST_COOL    = 2'd3
  } arb_state_t;

  localparam int OP_WIDTH_LSB = 0;
  localparam int OP_WIDTH_MSB = 1;
  localparam int OP_SIGN_BIT  = 2;
  localparam int OP_LOAD_BIT  = 3;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  localparam logic [3:0] OP_FETCH      = 4'b1010;
  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;
  localparam int         CNT_W         = 4;

  typedef struct packed {
    logic        is_data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  op;
  } mc_cmd_t;

  function automatic logic is_io_store(input logic is_load, input logic [1:0] seg,
                                       input logic [1:0] io_hi);
    return !is_load && (seg == io_hi);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational eligibility and priority select for one IDLE-cycle grant decision.
// Zero latency; an I/O store blocked by a full UART buffer yields to fetches.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
  input  logic       if_req,
  input  logic       flush,
  input  logic       ls_req,
  input  logic       ls_is_load,
  input  logic [1:0] ls_seg,
  input  logic       io_buffer_full,
  input  logic       starve_hit,
  output logic       pick_if,
  output logic       pick_ls
);

  logic ls_elig;
  logic if_elig;

  assign ls_elig = ls_req && !(is_io_store(ls_is_load, ls_seg, IO_HI) && io_buffer_full);
  assign if_elig = if_req && !flush;

  // Fetch wins only when data is not eligible or the starvation bound is reached.
  assign pick_if = if_elig && (!ls_elig || starve_hit);
  assign pick_ls = ls_elig && !pick_if;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of the byte-serial memory controller, one request in flight;
// grant 1 cycle after request, done 1 cycle after mc_done. Optional fetch fairness: ARB_FAIRNESS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_HI        = IO_HI_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_op,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        flush,
  input  logic        io_buffer_full,
  output logic        mc_req,
  output logic        mc_is_data,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [3:0]  mc_op,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  arb_state_t state;
  mc_cmd_t    cmd;
  logic       drop;
  logic       drop_now;
  logic       pick_if;
  logic       pick_ls;
  logic       starve_hit;

`ifdef ARB_FAIRNESS_EN
  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt <= '0;
    end else if (rdy_in && state == ST_IDLE) begin
      if (pick_if) starve_cnt <= '0;
      else if (pick_ls) starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_starve_limit;
  assign unused_starve_limit = CNT_W'(STARVE_LIMIT);
  assign starve_hit          = 1'b0;
`endif

  mem_arb_pick #(.IO_HI(IO_HI)) u_pick (
    .if_req         (if_req),
    .flush          (flush),
    .ls_req         (ls_req),
    .ls_is_load     (ls_op[OP_LOAD_BIT]),
    .ls_seg         (ls_addr[17:16]),
    .io_buffer_full (io_buffer_full),
    .starve_hit     (starve_hit),
    .pick_if        (pick_if),
    .pick_ls        (pick_ls)
  );

  // A flush in the completion cycle itself must also drop the result; stores never drop.
  assign drop_now = drop || (flush && (state == ST_BUSY_IF || cmd.op[OP_LOAD_BIT]));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      cmd      <= '0;
      drop     <= 1'b0;
      mc_req   <= 1'b0;
      if_gnt   <= 1'b0;
      ls_gnt   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy_in) begin
      if_gnt  <= 1'b0;
      ls_gnt  <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          drop <= 1'b0;
          if (pick_ls) begin
            cmd    <= '{is_data: 1'b1, addr: ls_addr, wdata: ls_wdata, op: ls_op};
            mc_req <= 1'b1;
            ls_gnt <= 1'b1;
            state  <= ST_BUSY_LS;
          end else if (pick_if) begin
            cmd    <= '{is_data: 1'b0, addr: if_addr, wdata: 32'h0, op: OP_FETCH};
            mc_req <= 1'b1;
            if_gnt <= 1'b1;
            state  <= ST_BUSY_IF;
          end
        end
        ST_BUSY_IF, ST_BUSY_LS: begin
          if (mc_done) begin
            mc_req <= 1'b0;
            drop   <= 1'b0;
            state  <= ST_COOL;
            if (state == ST_BUSY_IF) begin
              if_data <= mc_rdata;
              if_done <= !drop_now;
            end else begin
              ls_rdata <= mc_rdata;
              ls_done  <= !drop_now;
            end
          end else if (drop_now) begin
            drop <= 1'b1;
          end
        end
        ST_COOL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mc_is_data = cmd.is_data;
  assign mc_addr    = cmd.addr;
  assign mc_wdata   = cmd.wdata;
  assign mc_op      = cmd.op;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant-decision vector table plus hand sequences
// for completion timing, flush drops, fairness, rdy_in stall and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_op;
  logic        ls_gnt;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        flush;
  logic        io_buffer_full;
  logic        mc_req;
  logic        mc_is_data;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [3:0]  mc_op;
  logic        mc_done;
  logic [31:0] mc_rdata;

  mem_arbiter #(.STARVE_LIMIT(4), .IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_op(ls_op),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .flush(flush), .io_buffer_full(io_buffer_full),
    .mc_req(mc_req), .mc_is_data(mc_is_data), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_op(mc_op), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        ls_req;
    logic [31:0] ls_addr;
    logic [3:0]  ls_op;
    logic        io_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic        exp_if_gnt;
    logic        exp_ls_gnt;
    logic [31:0] exp_addr;
    logic [3:0]  exp_op;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; ls_req = 1'b0; flush = 1'b0; io_buffer_full = 1'b0; mc_done = 1'b0;
  endtask

  task automatic complete(input logic [31:0] rdata);
    mc_done  = 1'b1;
    mc_rdata = rdata;
    tick();
    mc_done  = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mc_req"}, 32'(mc_req), 32'h0);
    chk({tag, "_mc_is_data"}, 32'(mc_is_data), 32'h0);
    chk({tag, "_mc_addr"}, mc_addr, 32'h0);
    chk({tag, "_mc_wdata"}, mc_wdata, 32'h0);
    chk({tag, "_mc_op"}, 32'(mc_op), 32'h0);
    chk({tag, "_pulses"}, {28'h0, if_gnt, ls_gnt, if_done, ls_done}, 32'h0);
    chk({tag, "_if_data"}, if_data, 32'h0);
    chk({tag, "_ls_rdata"}, ls_rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic exp_fetch;
    logic got;
    int   w;

    vecs[0] = '{1'b1, 32'h1000,  4'b1010, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 32'h1000,  4'b1010};
    vecs[1] = '{1'b0, 32'h0,     4'b0000, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h40,    4'b1010};
    vecs[2] = '{1'b0, 32'h0,     4'b0000, 1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h0,     4'b0000};
    vecs[3] = '{1'b1, 32'h30000, 4'b0000, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,     4'b0000};
    vecs[4] = '{1'b1, 32'h30000, 4'b0000, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h80,    4'b1010};
    vecs[5] = '{1'b1, 32'h30000, 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h30000, 4'b0000};
    vecs[6] = '{1'b1, 32'h30004, 4'b1000, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h30004, 4'b1000};
    vecs[7] = '{1'b1, 32'h20000, 4'b0001, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h20000, 4'b0001};
    vecs[8] = '{1'b1, 32'h2000,  4'b1110, 1'b0, 1'b1, 32'h90, 1'b1, 1'b0, 1'b1, 32'h2000,  4'b1110};
    vecs[9] = '{1'b0, 32'h0,     4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,     4'b0000};

    rdy_in = 1'b1; if_addr = '0; ls_addr = '0; ls_wdata = 32'h41; ls_op = '0; mc_rdata = '0;
    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    rst_in = 1'b0;
    tick();
    chk("post_reset_mc_req", 32'(mc_req), 32'h0);

    // Grant-decision table, each vector starting from IDLE.
    for (int i = 0; i < 10; i++) begin
      ls_req = vecs[i].ls_req; ls_addr = vecs[i].ls_addr; ls_op = vecs[i].ls_op;
      io_buffer_full = vecs[i].io_full; if_req = vecs[i].if_req;
      if_addr = vecs[i].if_addr; flush = vecs[i].flush;
      tick();
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].exp_if_gnt));
      chk($sformatf("v%0d_ls_gnt", i), 32'(ls_gnt), 32'(vecs[i].exp_ls_gnt));
      chk($sformatf("v%0d_mc_req", i), 32'(mc_req), 32'(vecs[i].exp_if_gnt | vecs[i].exp_ls_gnt));
      idle_inputs();
      if (vecs[i].exp_if_gnt || vecs[i].exp_ls_gnt) begin
        chk($sformatf("v%0d_mc_addr", i), mc_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_mc_op", i), 32'(mc_op), 32'(vecs[i].exp_op));
        chk($sformatf("v%0d_mc_is_data", i), 32'(mc_is_data), 32'(vecs[i].exp_ls_gnt));
        if (vecs[i].exp_ls_gnt) chk($sformatf("v%0d_mc_wdata", i), mc_wdata, 32'h41);
        tick();
        chk($sformatf("v%0d_gnt_pulse_end", i), 32'(if_gnt | ls_gnt), 32'h0);
        complete(32'hA500_0000 + 32'(i));
        chk($sformatf("v%0d_if_done", i), 32'(if_done), 32'(vecs[i].exp_if_gnt));
        chk($sformatf("v%0d_ls_done", i), 32'(ls_done), 32'(vecs[i].exp_ls_gnt));
        chk($sformatf("v%0d_mc_req_drop", i), 32'(mc_req), 32'h0);
        chk($sformatf("v%0d_rdata", i), vecs[i].exp_if_gnt ? if_data : ls_rdata,
            32'hA500_0000 + 32'(i));
        tick();
      end
    end

    // Data beats fetch; fetch granted two cycles after the load's done pulse.
    do_reset();
    ls_req = 1'b1; ls_addr = 32'h1000; ls_op = 4'b1010; if_req = 1'b1; if_addr = 32'h0;
    tick();
    chk("prio_ls_gnt", 32'(ls_gnt), 32'h1);
    chk("prio_if_gnt", 32'(if_gnt), 32'h0);
    ls_req = 1'b0;
    tick();
    tick();
    complete(32'hDEADBEEF);
    chk("prio_ls_done", 32'(ls_done), 32'h1);
    chk("prio_ls_rdata", ls_rdata, 32'hDEADBEEF);
    tick();
    chk("prio_cool_no_gnt", 32'(if_gnt), 32'h0);
    chk("prio_ls_done_pulse", 32'(ls_done), 32'h0);
    tick();
    chk("prio_if_gnt_late", 32'(if_gnt), 32'h1);
    chk("prio_if_addr", mc_addr, 32'h0);
    if_req = 1'b0;
    tick();
    complete(32'h13);
    chk("prio_if_done", 32'(if_done), 32'h1);
    chk("prio_if_data", if_data, 32'h13);
    tick();

    // Blocked I/O store lets a fetch through, then goes after the fetch completes.
    ls_req = 1'b1; ls_addr = 32'h30000; ls_op = 4'b0000; ls_wdata = 32'h41;
    io_buffer_full = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("io_if_gnt", 32'(if_gnt), 32'h1);
    chk("io_ls_held", 32'(ls_gnt), 32'h0);
    if_req = 1'b0; io_buffer_full = 1'b0;
    tick();
    chk("io_busy_no_gnt", 32'(ls_gnt), 32'h0);
    complete(32'h22);
    chk("io_if_done", 32'(if_done), 32'h1);
    tick();
    chk("io_cool_no_gnt", 32'(ls_gnt), 32'h0);
    tick();
    chk("io_ls_gnt", 32'(ls_gnt), 32'h1);
    chk("io_wdata", mc_wdata, 32'h41);
    chk("io_addr", mc_addr, 32'h30000);
    ls_req = 1'b0;
    tick();
    complete(32'h0);
    chk("io_ls_done", 32'(ls_done), 32'h1);
    tick();

    // Flushed fetch: transaction finishes, result dropped, next fetch normal.
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    chk("fl_if_gnt", 32'(if_gnt), 32'h1);
    if_req = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("fl_mc_req_held", 32'(mc_req), 32'h1);
    complete(32'h33);
    chk("fl_if_done_dropped", 32'(if_done), 32'h0);
    chk("fl_mc_req_drop", 32'(mc_req), 32'h0);
    tick();
    if_req = 1'b1; if_addr = 32'h204;
    tick();
    chk("fl_next_if_gnt", 32'(if_gnt), 32'h1);
    if_req = 1'b0;
    tick();
    complete(32'h44);
    chk("fl_next_if_done", 32'(if_done), 32'h1);
    chk("fl_next_if_data", if_data, 32'h44);
    tick();

    // Flush coinciding with mc_done on a load drops the result.
    ls_req = 1'b1; ls_addr = 32'h1000; ls_op = 4'b1010;
    tick();
    chk("fld_ls_gnt", 32'(ls_gnt), 32'h1);
    ls_req = 1'b0;
    tick();
    flush = 1'b1;
    complete(32'h55);
    flush = 1'b0;
    chk("fld_ls_done_dropped", 32'(ls_done), 32'h0);
    chk("fld_ls_rdata", ls_rdata, 32'h55);
    tick();

    // Store is never dropped by flush.
    ls_req = 1'b1; ls_addr = 32'h1000; ls_op = 4'b0010;
    tick();
    chk("st_ls_gnt", 32'(ls_gnt), 32'h1);
    ls_req = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    complete(32'h0);
    chk("st_ls_done", 32'(ls_done), 32'h1);
    tick();

    // Fairness: data held high with a pending fetch.
    do_reset();
    ls_req = 1'b1; ls_addr = 32'h2000; ls_op = 4'b1010; if_req = 1'b1; if_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (!(if_gnt || ls_gnt) && w < 8);
      got = if_gnt || ls_gnt;
      chk($sformatf("fair%0d_grant_seen", k), 32'(got), 32'h1);
`ifdef ARB_FAIRNESS_EN
      exp_fetch = (k % 5 == 4);
`else
      exp_fetch = 1'b0;
`endif
      chk($sformatf("fair%0d_is_fetch", k), 32'(if_gnt), 32'(exp_fetch));
      tick();
      complete(32'(k));
    end
    idle_inputs();
    tick();

    // rdy_in stall during BUSY_LS freezes outputs, pulses included.
    ls_req = 1'b1; ls_addr = 32'h1000; ls_op = 4'b1010;
    tick();
    chk("stall_ls_gnt", 32'(ls_gnt), 32'h1);
    ls_req = 1'b0;
    rdy_in = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("stall%0d_ls_gnt", s), 32'(ls_gnt), 32'h1);
      chk($sformatf("stall%0d_mc_req", s), 32'(mc_req), 32'h1);
      chk($sformatf("stall%0d_mc_addr", s), mc_addr, 32'h1000);
    end
    rdy_in = 1'b1;
    tick();
    chk("stall_gnt_clear", 32'(ls_gnt), 32'h0);
    chk("stall_mc_req", 32'(mc_req), 32'h1);
    complete(32'h66);
    chk("stall_ls_done", 32'(ls_done), 32'h1);
    chk("stall_ls_rdata", ls_rdata, 32'h66);
    tick();

    // Reset during BUSY_IF abandons the fetch.
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    chk("rst_if_gnt", 32'(if_gnt), 32'h1);
    if_req = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst_in = 1'b0;
    tick();
    chk("midrst_idle", 32'(mc_req), 32'h0);
    if_req = 1'b1; if_addr = 32'h404;
    tick();
    chk("midrst_if_gnt", 32'(if_gnt), 32'h1);
    chk("midrst_addr", mc_addr, 32'h404);
    if_req = 1'b0;
    tick();
    complete(32'h77);
    chk("midrst_if_done", 32'(if_done), 32'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
